vdp1_fb_dual: RTL

Double-buffered VDP1 frame buffer with a configurable depth. It holds two equal frame buffers: the draw side (command engine) accesses one, and the display side (scan-out) reads the other. It supports per-byte writes, a request/acknowledge buffer swap, and a background erase engine that clears an address range of the display buffer during idle display cycles. It sits between the VDP1 command/draw pipeline and the VDP2 pixel input, and replaces the single-buffer word-write frame buffer.

---
 rtl/vdp1_fb_dual.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/vdp1_fb_dual.sv
// Double-buffered VDP1 frame buffer: the draw port uses buffer !fb_sel, while scan-out and the
// background erase engine use buffer fb_sel. Buffer swaps wait until any running erase has finished.
module vdp1_fb_dual #(
    parameter int AW    = 17,
    parameter int DEPTH = 90112,
    parameter int DW    = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] draw_addr,
    input  logic [DW-1:0] draw_data,
    input  logic [1:0]    draw_wren,
    input  logic          draw_rd,
    output logic [DW-1:0] draw_q,
    output logic          draw_valid,
    input  logic [AW-1:0] disp_addr,
    input  logic          disp_rd,
    output logic [DW-1:0] disp_q,
    output logic          disp_valid,
    input  logic          swap_req,
    output logic          swap_ack,
    output logic          fb_sel,
    input  logic          erase_start,
    input  logic [AW-1:0] erase_first,
    input  logic [AW-1:0] erase_last,
    input  logic [DW-1:0] erase_value,
    output logic          erase_busy,
    output logic          erase_done
);

    localparam int HW = DW / 2;
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {ER_IDLE, ER_RUN, ER_DONE} er_state_t;

    er_state_t     er_state, er_state_nx;
    logic [AW-1:0] erase_ptr;
    logic [AW-1:0] erase_end;
    logic [DW-1:0] erase_val;
    logic          erase_step;
    logic          erase_we;
    logic          swap_pending;
    logic          swap_fire;

    logic [HW-1:0] ram_lo [2][DEPTH];
    logic [HW-1:0] ram_hi [2][DEPTH];

    logic [1:0]    bank_we_lo;
    logic [1:0]    bank_we_hi;
    logic [AW-1:0] bank_addr  [2];
    logic [DW-1:0] bank_wdata [2];

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    // The display bank is written only by the erase engine; the draw bank only by the draw port.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_we_lo[b] = 1'b0;
            bank_we_hi[b] = 1'b0;
            bank_addr[b]  = draw_addr;
            bank_wdata[b] = draw_data;
            if (fb_sel == 1'(b)) begin
                bank_we_lo[b] = erase_we;
                bank_we_hi[b] = erase_we;
                bank_addr[b]  = erase_ptr;
                bank_wdata[b] = erase_val;
            end else if (in_range(draw_addr)) begin
                bank_we_lo[b] = draw_wren[0];
                bank_we_hi[b] = draw_wren[1];
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int b = 0; b < 2; b++) begin
            if (bank_we_lo[b]) ram_lo[b][bank_addr[b]] <= bank_wdata[b][HW-1:0];
            if (bank_we_hi[b]) ram_hi[b][bank_addr[b]] <= bank_wdata[b][DW-1:HW];
        end
    end

    // Read stage: the registered read returns the pre-write contents on a same-address collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            draw_valid <= 1'b0;
            disp_valid <= 1'b0;
            draw_q     <= '0;
            disp_q     <= '0;
        end else begin
            draw_valid <= draw_rd;
            disp_valid <= disp_rd;
            if (draw_rd)
                draw_q <= in_range(draw_addr) ?
                          {ram_hi[~fb_sel][draw_addr], ram_lo[~fb_sel][draw_addr]} : '0;
            if (disp_rd)
                disp_q <= in_range(disp_addr) ?
                          {ram_hi[fb_sel][disp_addr], ram_lo[fb_sel][disp_addr]} : '0;
        end
    end

    // Erase advances only on cycles the display port leaves free.
    assign erase_step = (er_state == ER_RUN) && !disp_rd;
    assign erase_we   = erase_step && in_range(erase_ptr) && !reset;

    always_ff @(posedge clock) begin
        if (reset) er_state <= ER_IDLE;
        else       er_state <= er_state_nx;
    end

    always_comb begin
        er_state_nx = er_state;
        case (er_state)
            ER_IDLE: if (erase_start) er_state_nx = (erase_last < erase_first) ? ER_DONE : ER_RUN;
            ER_RUN:  if (erase_step && erase_ptr == erase_end) er_state_nx = ER_DONE;
            ER_DONE: er_state_nx = ER_IDLE;
            default: er_state_nx = ER_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (er_state == ER_IDLE && erase_start) begin
            erase_ptr <= erase_first;
            erase_end <= erase_last;
            erase_val <= erase_value;
        end else if (erase_step) begin
            erase_ptr <= erase_ptr + 1'b1;
        end
    end

    assign erase_busy = (er_state != ER_IDLE);
    assign erase_done = (er_state == ER_DONE);

    // Leaving DONE is the earliest edge a deferred swap may take effect.
    assign swap_fire = swap_pending && (er_state == ER_IDLE || er_state == ER_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            fb_sel       <= 1'b0;
            swap_ack     <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            fb_sel       <= fb_sel ^ swap_fire;
            swap_ack     <= swap_fire;
            swap_pending <= swap_fire ? 1'b0 : (swap_pending | swap_req);
        end
    end

endmodule
